// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM encoding, baud timing constants and a small
// sizing helper used by the feeder's shared counter.
package uart_pkg;
   localparam int UART_CLK_FREQ = 12_000_000;
   localparam int UART_BAUD     = 9600;
   localparam int CLKS_PER_BIT  = UART_CLK_FREQ / UART_BAUD;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_GAP
   } feeder_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/uart_tx_fifo_feeder_if.sv
// Byte-in valid/ready handshake plus the transmitter start/busy handshake of the feeder.
// The slave side is the feeder; the master side is the byte producer and transmitter.
interface uart_tx_fifo_feeder_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;

   modport master (
      output in_data, in_valid, tx_busy,
      input  in_ready, tx_start, tx_data
   );

   modport slave (
      input  in_data, in_valid, tx_busy,
      output in_ready, tx_start, tx_data
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and a combinational head read,
// so the consumer sees the oldest entry in the same cycle it decides to pop.
module sync_fifo #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty
);
   localparam int CW = ADDR_W + 1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + ADDR_W'(do_push);
      rd_ptr_d = rd_ptr_q + ADDR_W'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/uart_tx_fifo_feeder.sv
// Buffered byte source for the 8N1 transmitter: queues bytes in a FIFO and drains them
// one frame at a time, with an optional inter-frame gap and a busy-acknowledge timeout.
module uart_tx_fifo_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int ADDR_W       = 4,
   parameter int GAP_CLKS     = 0,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   uart_tx_fifo_feeder_if.slave  bus,
   output logic [ADDR_W:0]       fifo_count,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  idle,
   output logic                  err_timeout,
   input  logic                  err_clr
);
   // One counter serves both the busy timeout and the idle gap, so size it for the larger.
   localparam int CNT_W = $clog2(max_int(BUSY_TIMEOUT, GAP_CLKS) + 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT - 2);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(max_int(GAP_CLKS, 1) - 1);
   localparam feeder_state_e AFTER_FRAME = (GAP_CLKS == 0) ? S_IDLE : S_GAP;

   feeder_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tx_start_q, tx_start_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             err_q, err_d;
   logic             pop;
   logic [7:0]       head;

   sync_fifo #(
      .WIDTH  (8),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.in_valid),
      .pop   (pop),
      .din   (bus.in_data),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.in_ready = !fifo_full;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign err_timeout  = err_q;
   assign idle         = (state_q == S_IDLE) && fifo_empty;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      err_d      = err_q;
      pop        = 1'b0;
      if (err_clr) err_d = 1'b0;
      unique case (state_q)
         // A busy transmitter in idle belongs to someone else; hold off until it frees.
         S_IDLE: begin
            if (!fifo_empty && !bus.tx_busy) begin
               pop        = 1'b1;
               tx_data_d  = head;
               tx_start_d = 1'b1;
               state_d    = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (bus.tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = AFTER_FRAME;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               cnt_d   = '0;
               state_d = AFTER_FRAME;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) state_d = S_IDLE;
            else                   cnt_d   = cnt_q + CNT_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Bench for the UART feeder: two feeders (no gap / 20-cycle gap) driving behavioural
// 8N1 transmitters with an 8-clock bit time, checked against byte queues and timing rules.
module tb_uart_tx_fifo_feeder;
   import uart_pkg::*;

   localparam int CPB = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err_clr = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   uart_tx_fifo_feeder_if b0 ();
   uart_tx_fifo_feeder_if bg ();

   logic [4:0] fifo_count0, fifo_count_g;
   logic fifo_full0, fifo_empty0, idle0, err0;
   logic fifo_full_g, fifo_empty_g, idle_g, err_g;

   uart_tx_fifo_feeder #(.DEPTH(16), .ADDR_W(4), .GAP_CLKS(0), .BUSY_TIMEOUT(15)) dut0 (
      .clk(clk), .rst(rst), .bus(b0), .fifo_count(fifo_count0), .fifo_full(fifo_full0),
      .fifo_empty(fifo_empty0), .idle(idle0), .err_timeout(err0), .err_clr(err_clr));

   uart_tx_fifo_feeder #(.DEPTH(16), .ADDR_W(4), .GAP_CLKS(20), .BUSY_TIMEOUT(15)) dutg (
      .clk(clk), .rst(rst), .bus(bg), .fifo_count(fifo_count_g), .fifo_full(fifo_full_g),
      .fifo_empty(fifo_empty_g), .idle(idle_g), .err_timeout(err_g), .err_clr(err_clr));

   always #5 clk = ~clk;

   // Behavioural transmitter for dut0: accepts a start when free, busy for 10 bit times.
   logic       busy_r0, disc0 = 1'b0, foreign0 = 1'b0, serial0;
   int         tcnt0, start_cyc0 = 0;
   logic [9:0] frame0;
   logic [7:0] got0 [$];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r0 <= 1'b0; tcnt0 <= 0; frame0 <= '1;
      end else begin
         if (b0.tx_start) start_cyc0 <= start_cyc0 + 1;
         if (!busy_r0) begin
            if (b0.tx_start && !disc0) begin
               busy_r0 <= 1'b1; tcnt0 <= 0; frame0 <= {1'b1, b0.tx_data, 1'b0};
               got0.push_back(b0.tx_data);
            end
         end else if (tcnt0 == 10 * CPB - 1) busy_r0 <= 1'b0;
         else tcnt0 <= tcnt0 + 1;
      end
   end
   assign serial0    = busy_r0 ? frame0[tcnt0 / CPB] : 1'b1;
   assign b0.tx_busy = disc0 ? 1'b0 : (busy_r0 | foreign0);

   logic       busy_rg;
   int         tcntg;
   logic [7:0] got_g [$];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_rg <= 1'b0; tcntg <= 0;
      end else if (!busy_rg) begin
         if (bg.tx_start) begin
            busy_rg <= 1'b1; tcntg <= 0; got_g.push_back(bg.tx_data);
         end
      end else if (tcntg == 10 * CPB - 1) busy_rg <= 1'b0;
      else tcntg <= tcntg + 1;
   end
   assign bg.tx_busy = busy_rg;

   task automatic wait_drain0(input int target, output bit ok);
      int t = 0;
      while (!(got0.size() == target && idle0 && !b0.tx_busy) && t < 4000) begin
         @(negedge clk); t++;
      end
      ok = (t < 4000);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({b0.in_ready, b0.tx_start, b0.tx_data} !== {1'b1, 1'b0, 8'h00}) begin
         n_fail++; $display("FAIL reset_handshake: got %b expected %b",
                            {b0.in_ready, b0.tx_start, b0.tx_data}, 10'b10_0000_0000);
      end
      n_checks++;
      if ({fifo_count0, fifo_full0, fifo_empty0, idle0, err0} !== 9'b00000_0110) begin
         n_fail++; $display("FAIL reset_status: got %b expected %b",
                            {fifo_count0, fifo_full0, fifo_empty0, idle0, err0}, 9'b00000_0110);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (idle0 !== 1'b1 || b0.tx_start !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: idle %b tx_start %b expected 1 0", idle0, b0.tx_start);
      end
   endtask

   task automatic test_single();
      int   base = got0.size();
      int   t = 0;
      logic line [80];
      logic [9:0] rx;
      b0.in_data = 8'hA5; b0.in_valid = 1'b1;
      @(negedge clk);
      b0.in_valid = 1'b0;
      n_checks++;
      if (b0.tx_start !== 1'b0 || fifo_count0 !== 5'd1) begin
         n_fail++; $display("FAIL single_early: tx_start %b count %0d expected 0 1", b0.tx_start, fifo_count0);
      end
      @(negedge clk);
      n_checks++;
      if (b0.tx_start !== 1'b1 || b0.tx_data !== 8'hA5) begin
         n_fail++; $display("FAIL single_start: tx_start %b data %h expected 1 a5", b0.tx_start, b0.tx_data);
      end
      @(posedge clk);
      for (int j = 0; j < 80; j++) begin
         @(negedge clk);
         line[j] = serial0;
         if (j == 0) begin
            n_checks++;
            if (b0.tx_start !== 1'b0) begin
               n_fail++; $display("FAIL single_pulse: tx_start %b expected 0", b0.tx_start);
            end
         end
      end
      for (int k = 0; k < 10; k++) rx[k] = line[8 * k + 4];
      n_checks++;
      if (rx !== {1'b1, 8'hA5, 1'b0}) begin
         n_fail++; $display("FAIL single_serial: got %b expected %b", rx, {1'b1, 8'hA5, 1'b0});
      end
      while (b0.tx_busy && t < 20) begin @(negedge clk); t++; end
      n_checks++;
      if (t >= 20 || idle0 !== 1'b0) begin
         n_fail++; $display("FAIL single_fall: waited %0d idle %b expected <20 0", t, idle0);
      end
      @(negedge clk);
      n_checks++;
      if (idle0 !== 1'b1 || got0.size() != base + 1 || got0[base] !== 8'hA5) begin
         n_fail++; $display("FAIL single_idle: idle %b frames %0d expected 1 1", idle0, got0.size() - base);
      end
   endtask

   task automatic test_burst();
      int   base = got0.size(), s0 = start_cyc0, sent = 0, t = 0;
      int   fall_t = -1, maxgap = 0, ngaps = 0;
      logic prev = 1'b0, acc, bad = 1'b0;
      foreign0 = 1'b1;
      b0.in_valid = 1'b1;
      while (sent < 16 && t < 100) begin
         b0.in_data = 8'(sent);
         acc = b0.in_ready;
         @(negedge clk);
         if (acc) sent++;
         t++;
      end
      n_checks++;
      if (fifo_count0 !== 5'd16 || fifo_full0 !== 1'b1 || b0.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL burst_full: count %0d full %b ready %b expected 16 1 0",
                            fifo_count0, fifo_full0, b0.in_ready);
      end
      b0.in_data = 8'hFF;
      repeat (3) @(negedge clk);
      b0.in_valid = 1'b0;
      n_checks++;
      if (fifo_count0 !== 5'd16 || start_cyc0 != s0) begin
         n_fail++; $display("FAIL burst_hold: count %0d starts %0d expected 16 0", fifo_count0, start_cyc0 - s0);
      end
      foreign0 = 1'b0;
      t = 0;
      while (!(got0.size() == base + 16 && idle0 && !b0.tx_busy) && t < 4000) begin
         @(negedge clk); t++;
         if (prev && !b0.tx_busy) fall_t = t;
         if (b0.tx_start && fall_t >= 0) begin
            ngaps++;
            if (t - fall_t > maxgap) maxgap = t - fall_t;
            fall_t = -1;
         end
         prev = b0.tx_busy;
      end
      for (int i = 0; i < 16; i++) if (got0.size() <= base + i || got0[base + i] !== 8'(i)) bad = 1'b1;
      n_checks++;
      if (t >= 4000 || bad) begin
         n_fail++; $display("FAIL burst_order: frames %0d in_order %b expected 16 1", got0.size() - base, !bad);
      end
      n_checks++;
      if (maxgap != 2 || ngaps != 15) begin
         n_fail++; $display("FAIL burst_gap: max %0d count %0d expected 2 15", maxgap, ngaps);
      end
      n_checks++;
      if (fifo_empty0 !== 1'b1 || start_cyc0 - s0 != 16) begin
         n_fail++; $display("FAIL burst_end: empty %b starts %0d expected 1 16", fifo_empty0, start_cyc0 - s0);
      end
   endtask

   task automatic test_gap();
      int   base = got_g.size(), t = 0, fall_t = -1, gap = -1, nstart = 0;
      logic prev = 1'b0;
      bg.in_valid = 1'b1; bg.in_data = 8'h11;
      @(negedge clk);
      bg.in_data = 8'h22;
      @(negedge clk);
      bg.in_valid = 1'b0;
      while (!(got_g.size() == base + 2 && idle_g && !bg.tx_busy) && t < 1000) begin
         if (prev && !bg.tx_busy) fall_t = t;
         if (bg.tx_start) begin
            nstart++;
            if (nstart == 2) gap = t - fall_t;
         end
         prev = bg.tx_busy;
         @(negedge clk); t++;
      end
      n_checks++;
      if (gap != 22 || nstart != 2) begin
         n_fail++; $display("FAIL gap_len: got %0d starts %0d expected 22 2", gap, nstart);
      end
      n_checks++;
      if (t >= 1000 || got_g.size() != base + 2 || got_g[base] !== 8'h11 || got_g[base + 1] !== 8'h22) begin
         n_fail++; $display("FAIL gap_data: frames %0d expected 2 (11,22)", got_g.size() - base);
      end
   endtask

   task automatic test_simul();
      int         base = got0.size();
      bit         ok;
      logic       bad = 1'b0;
      logic [7:0] exp_q [$];
      foreign0 = 1'b1;
      b0.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         b0.in_data = 8'($urandom_range(0, 255));
         exp_q.push_back(b0.in_data);
         @(negedge clk);
      end
      b0.in_valid = 1'b0;
      n_checks++;
      if (fifo_count0 !== 5'd5) begin
         n_fail++; $display("FAIL simul_pre: count %0d expected 5", fifo_count0);
      end
      b0.in_valid = 1'b1;
      b0.in_data = 8'($urandom_range(0, 255));
      exp_q.push_back(b0.in_data);
      foreign0 = 1'b0;
      @(negedge clk);
      b0.in_valid = 1'b0;
      n_checks++;
      if (fifo_count0 !== 5'd5 || b0.tx_start !== 1'b1) begin
         n_fail++; $display("FAIL simul_count: count %0d tx_start %b expected 5 1", fifo_count0, b0.tx_start);
      end
      wait_drain0(base + 6, ok);
      for (int i = 0; i < 6; i++) if (got0.size() <= base + i || got0[base + i] !== exp_q[i]) bad = 1'b1;
      n_checks++;
      if (!ok || bad) begin
         n_fail++; $display("FAIL simul_order: frames %0d in_order %b expected 6 1", got0.size() - base, !bad);
      end
   endtask

   task automatic test_random();
      int         base = got0.size(), sent = 0, t = 0;
      bit         ok;
      logic       bad = 1'b0;
      logic [7:0] exp_q [$];
      while (sent < 12 && t < 2000) begin
         b0.in_valid = 1'($urandom_range(0, 1));
         b0.in_data  = 8'($urandom_range(0, 255));
         if (b0.in_valid && b0.in_ready) begin
            exp_q.push_back(b0.in_data); sent++;
         end
         @(negedge clk); t++;
      end
      b0.in_valid = 1'b0;
      wait_drain0(base + exp_q.size(), ok);
      for (int i = 0; i < exp_q.size(); i++)
         if (got0.size() <= base + i || got0[base + i] !== exp_q[i]) bad = 1'b1;
      n_checks++;
      if (!ok || bad || sent != 12) begin
         n_fail++; $display("FAIL random_order: frames %0d sent %0d in_order %b expected 12 12 1",
                            got0.size() - base, sent, !bad);
      end
   endtask

   task automatic test_timeout();
      int base = got0.size(), k = 0;
      disc0 = 1'b1;
      b0.in_valid = 1'b1; b0.in_data = 8'h3C;
      @(negedge clk);
      b0.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (b0.tx_start !== 1'b1) begin
         n_fail++; $display("FAIL to_start: tx_start %b expected 1", b0.tx_start);
      end
      while (!err0 && k < 40) begin @(negedge clk); k++; end
      n_checks++;
      if (k != 15) begin
         n_fail++; $display("FAIL to_delay: got %0d cycles expected 15", k);
      end
      n_checks++;
      if (fifo_empty0 !== 1'b1 || idle0 !== 1'b1 || got0.size() != base) begin
         n_fail++; $display("FAIL to_drop: empty %b idle %b frames %0d expected 1 1 0",
                            fifo_empty0, idle0, got0.size() - base);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_checks++;
      if (err0 !== 1'b0) begin
         n_fail++; $display("FAIL to_clear: err %b expected 0", err0);
      end
      b0.in_valid = 1'b1; b0.in_data = 8'h5A;
      @(negedge clk);
      b0.in_valid = 1'b0;
      @(negedge clk);
      repeat (14) @(negedge clk);
      n_checks++;
      if (err0 !== 1'b0) begin
         n_fail++; $display("FAIL to_early: err %b expected 0", err0);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_checks++;
      if (err0 !== 1'b1) begin
         n_fail++; $display("FAIL to_set_priority: err %b expected 1", err0);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      disc0 = 1'b0;
   endtask

   task automatic test_reset_mid();
      int   base = got0.size(), t = 0, s0;
      bit   ok;
      foreign0 = 1'b1;
      b0.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b0.in_data = 8'h40 + 8'(i);
         @(negedge clk);
      end
      b0.in_valid = 1'b0;
      foreign0 = 1'b0;
      while (!busy_r0 && t < 10) begin @(negedge clk); t++; end
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({fifo_count0, fifo_empty0, fifo_full0, idle0, b0.in_ready, b0.tx_start, b0.tx_data, err0}
          !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
         n_fail++; $display("FAIL midrst_state: count %0d idle %b tx_start %b data %h expected 0 1 0 00",
                            fifo_count0, idle0, b0.tx_start, b0.tx_data);
      end
      rst = 1'b0;
      s0 = start_cyc0;
      repeat (150) @(negedge clk);
      n_checks++;
      if (start_cyc0 != s0 || fifo_count0 !== 5'd0) begin
         n_fail++; $display("FAIL midrst_quiet: starts %0d count %0d expected 0 0", start_cyc0 - s0, fifo_count0);
      end
      b0.in_valid = 1'b1; b0.in_data = 8'h77;
      @(negedge clk);
      b0.in_valid = 1'b0;
      wait_drain0(base + 2, ok);
      n_checks++;
      if (!ok || got0[base] !== 8'h40 || got0[base + 1] !== 8'h77) begin
         n_fail++; $display("FAIL midrst_resume: frames %0d expected 2 (40,77)", got0.size() - base);
      end
   endtask

   initial begin
      b0.in_valid = 1'b0; b0.in_data = 8'h00;
      bg.in_valid = 1'b0; bg.in_data = 8'h00;
      test_reset();
      test_single();
      test_burst();
      test_gap();
      test_simul();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end
endmodule
